// File: rtl/uart_pkg.sv
// Shared definitions for the CoreUART host sequencer: FSM state encoding and
// the default guard length.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WR         = 2'd1,
    RD         = 2'd2,
    GUARD_WAIT = 2'd3
  } state_t;

  localparam int GUARD_DEFAULT = 3;

endpackage

// File: rtl/uart_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module uart_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/uart_core_host.sv
// Host sequencer for the CoreUART parallel port: turns a TX byte stream into
// write strobes and drains received bytes (with error flags) into an RX stream.
import uart_pkg::*;

module uart_core_host #(
  parameter int GUARD = GUARD_DEFAULT,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [7:0]       TX_DATA,
  input  logic             TX_VALID,
  output logic             TX_READY,
  output logic [7:0]       RX_DATA,
  output logic             RX_PERR,
  output logic             RX_FERR,
  output logic             RX_VALID,
  input  logic             RX_READY,
  output logic             CSN,
  output logic             WEN,
  output logic             OEN,
  output logic [7:0]       DATA_IN,
  input  logic [7:0]       DATA_OUT,
  input  logic             TXRDY,
  input  logic             RXRDY,
  input  logic             PARITY_ERR,
  input  logic             FRAMING_ERR,
  input  logic             OVERFLOW,
  output logic [CNT_W-1:0] PERR_CNT,
  output logic [CNT_W-1:0] FERR_CNT,
  output logic [CNT_W-1:0] OVF_CNT,
  input  logic             CNT_CLR
);

  localparam logic [3:0] GUARD_LOAD = 4'(GUARD - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] guard_cnt;
  logic       rx_take;
  logic       tx_accept;
  logic       capture;
  logic       ovf_q;

  // A read is only issued when the one-entry RX holding register can take it.
  assign rx_take   = RXRDY & (~RX_VALID | RX_READY);
  assign TX_READY  = (state == IDLE) & TXRDY & ~rx_take;
  assign tx_accept = TX_VALID & TX_READY;
  assign capture   = (state == RD);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (rx_take) begin
          state_nxt = RD;
        end else if (tx_accept) begin
          state_nxt = WR;
        end
      end
      WR:         state_nxt = GUARD_WAIT;
      RD:         state_nxt = GUARD_WAIT;
      GUARD_WAIT: begin
        if (guard_cnt == 4'd0) begin
          state_nxt = IDLE;
        end
      end
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      guard_cnt <= 4'd0;
      CSN       <= 1'b1;
      WEN       <= 1'b1;
      OEN       <= 1'b1;
      DATA_IN   <= 8'h00;
      RX_DATA   <= 8'h00;
      RX_PERR   <= 1'b0;
      RX_FERR   <= 1'b0;
      RX_VALID  <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      // Strobes are registered from the next state so they are glitch-free
      // and low exactly for the single WR/RD cycle.
      CSN   <= ~((state_nxt == WR) || (state_nxt == RD));
      WEN   <= (state_nxt != WR);
      OEN   <= (state_nxt != RD);

      if ((state_nxt == GUARD_WAIT) && (state != GUARD_WAIT)) begin
        guard_cnt <= GUARD_LOAD;
      end else if ((state == GUARD_WAIT) && (guard_cnt != 4'd0)) begin
        guard_cnt <= guard_cnt - 4'd1;
      end

      if (tx_accept) begin
        DATA_IN <= TX_DATA;
      end

      if (capture) begin
        RX_DATA  <= DATA_OUT;
        RX_PERR  <= PARITY_ERR;
        RX_FERR  <= FRAMING_ERR;
        RX_VALID <= 1'b1;
      end else if (RX_READY) begin
        RX_VALID <= 1'b0;
      end

      ovf_q <= OVERFLOW;
    end
  end

  uart_sat_cnt #(.W(CNT_W)) u_perr_cnt (
    .clk   (CLK),
    .reset (RESET),
    .clr   (CNT_CLR),
    .inc   (capture & PARITY_ERR),
    .cnt   (PERR_CNT)
  );

  uart_sat_cnt #(.W(CNT_W)) u_ferr_cnt (
    .clk   (CLK),
    .reset (RESET),
    .clr   (CNT_CLR),
    .inc   (capture & FRAMING_ERR),
    .cnt   (FERR_CNT)
  );

  uart_sat_cnt #(.W(CNT_W)) u_ovf_cnt (
    .clk   (CLK),
    .reset (RESET),
    .clr   (CNT_CLR),
    .inc   (OVERFLOW & ~ovf_q),
    .cnt   (OVF_CNT)
  );

endmodule

// File: tb/tb_uart_core_host.sv
// Scoreboard bench for uart_core_host: expected writes and received words are
// queued at issue time and popped by a monitor when the DUT presents them.
module tb_uart_core_host;

  localparam int GUARD = 3;
  localparam int CNT_W = 2;

  logic             CLK = 1'b0;
  logic             RESET = 1'b1;
  logic [7:0]       TX_DATA = 8'h11;
  logic             TX_VALID = 1'b1;
  logic             TX_READY;
  logic [7:0]       RX_DATA;
  logic             RX_PERR;
  logic             RX_FERR;
  logic             RX_VALID;
  logic             RX_READY = 1'b0;
  logic             CSN;
  logic             WEN;
  logic             OEN;
  logic [7:0]       DATA_IN;
  logic [7:0]       DATA_OUT = 8'h00;
  logic             TXRDY = 1'b1;
  logic             RXRDY = 1'b1;
  logic             PARITY_ERR = 1'b0;
  logic             FRAMING_ERR = 1'b0;
  logic             OVERFLOW = 1'b0;
  logic [CNT_W-1:0] PERR_CNT;
  logic [CNT_W-1:0] FERR_CNT;
  logic [CNT_W-1:0] OVF_CNT;
  logic             CNT_CLR = 1'b0;

  uart_core_host #(.GUARD(GUARD), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RESET(RESET),
    .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
    .RX_DATA(RX_DATA), .RX_PERR(RX_PERR), .RX_FERR(RX_FERR),
    .RX_VALID(RX_VALID), .RX_READY(RX_READY),
    .CSN(CSN), .WEN(WEN), .OEN(OEN),
    .DATA_IN(DATA_IN), .DATA_OUT(DATA_OUT),
    .TXRDY(TXRDY), .RXRDY(RXRDY), .PARITY_ERR(PARITY_ERR),
    .FRAMING_ERR(FRAMING_ERR), .OVERFLOW(OVERFLOW),
    .PERR_CNT(PERR_CNT), .FERR_CNT(FERR_CNT), .OVF_CNT(OVF_CNT),
    .CNT_CLR(CNT_CLR)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rd_count = 0;
  bit mon_en = 1'b0;

  logic [7:0] wr_q[$];
  logic [9:0] rx_q[$];
  logic [7:0] wr_exp;
  logic [9:0] rx_exp;
  logic       strobe_ok;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: strobe legality every cycle, writes and RX handshakes vs queues.
  always @(negedge CLK) begin
    if (mon_en) begin
      strobe_ok = (CSN & WEN & OEN) | (~CSN & ~WEN & OEN) | (~CSN & WEN & ~OEN);
      chk("strobe_rule", {31'd0, strobe_ok}, 32'd1);
      if (!CSN && !WEN) begin
        if (wr_q.size() == 0) begin
          chk("unexpected_write", DATA_IN, 32'hFFFF_FFFF);
        end else begin
          wr_exp = wr_q.pop_front();
          chk("wr_data", DATA_IN, wr_exp);
        end
      end
      if (!CSN && !OEN) rd_count++;
      if (RX_VALID && RX_READY) begin
        if (rx_q.size() == 0) begin
          chk("unexpected_rx", {RX_PERR, RX_FERR, RX_DATA}, 32'hFFFF_FFFF);
        end else begin
          rx_exp = rx_q.pop_front();
          chk("rx_word", {RX_PERR, RX_FERR, RX_DATA}, rx_exp);
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, output int acc_cyc);
    bit done;
    done = 1'b0;
    acc_cyc = -1;
    TX_DATA = d;
    TX_VALID = 1'b1;
    wr_q.push_back(d);
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge CLK);
      if (TX_READY) done = 1'b1;
      @(posedge CLK);
      #1;
      if (done) acc_cyc = cyc;
    end
    TX_VALID = 1'b0;
    chk("tx_accept", {31'd0, done}, 32'd1);
  endtask

  task automatic recv(input logic [7:0] d, input bit pe, input bit fe, input bit clr);
    bit seen;
    seen = 1'b0;
    DATA_OUT = d;
    PARITY_ERR = pe;
    FRAMING_ERR = fe;
    RXRDY = 1'b1;
    rx_q.push_back({pe, fe, d});
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge CLK);
      if (!OEN) seen = 1'b1;
    end
    chk("rd_strobe", {31'd0, seen}, 32'd1);
    RXRDY = 1'b0;
    CNT_CLR = clr;
    @(posedge CLK);
    #1;
    CNT_CLR = 1'b0;
  endtask

  task automatic wait_idle();
    repeat (8) @(posedge CLK);
    #1;
  endtask

  task automatic wait_strobe(input bit want_wr, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge CLK);
      if (want_wr ? !WEN : !OEN) seen = 1'b1;
    end
    chk(name, {31'd0, seen}, 32'd1);
  endtask

  int a1, a2, a3, rc, n0;
  logic [1:0] ferr_tbl [5];

  initial begin
    ferr_tbl = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    // Reset held with traffic pending: strobes must stay idle.
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      #1;
      chk("reset_strobes", {CSN, WEN, OEN}, 3'b111);
    end
    chk("reset_rx_valid", RX_VALID, 0);
    chk("reset_rx_word", {RX_PERR, RX_FERR, RX_DATA}, 0);
    chk("reset_data_in", DATA_IN, 0);
    chk("reset_counters", {PERR_CNT, FERR_CNT, OVF_CNT}, 0);
    TX_VALID = 1'b0;
    RXRDY = 1'b0;
    RESET = 1'b0;
    RX_READY = 1'b1;
    mon_en = 1'b1;
    @(posedge CLK);
    #1;

    // TX: single-cycle write strobe, back-to-back spacing of 2+GUARD.
    send(8'hA5, a1);
    @(negedge CLK);
    chk("wr_latency", {CSN, WEN, OEN}, 3'b001);
    send(8'h5A, a2);
    chk("tx_spacing", a2 - a1, 2 + GUARD);
    wait_idle();
    chk("data_in_hold", DATA_IN, 8'h5A);

    // RX with parity error, consumer stalled until checked.
    RX_READY = 1'b0;
    DATA_OUT = 8'h3C;
    PARITY_ERR = 1'b1;
    FRAMING_ERR = 1'b0;
    rx_q.push_back({1'b1, 1'b0, 8'h3C});
    RXRDY = 1'b1;
    @(negedge CLK);
    chk("rd_not_yet", {CSN, WEN, OEN}, 3'b111);
    @(negedge CLK);
    chk("rd_latency", {CSN, WEN, OEN}, 3'b010);
    chk("rx_valid_early", RX_VALID, 0);
    RXRDY = 1'b0;
    @(negedge CLK);
    chk("rx_valid", RX_VALID, 1);
    chk("rx_data", RX_DATA, 8'h3C);
    chk("rx_perr", {RX_PERR, RX_FERR}, 2'b10);
    chk("perr_cnt", PERR_CNT, 1);
    @(posedge CLK);
    #1;
    RX_READY = 1'b1;
    @(posedge CLK);
    #1;
    chk("rx_valid_cleared", RX_VALID, 0);
    PARITY_ERR = 1'b0;

    // Contention: read wins, write follows after the guard.
    wait_idle();
    DATA_OUT = 8'hC3;
    FRAMING_ERR = 1'b1;
    rx_q.push_back({1'b0, 1'b1, 8'hC3});
    RXRDY = 1'b1;
    TX_DATA = 8'h7E;
    TX_VALID = 1'b1;
    @(negedge CLK);
    chk("tx_ready_blocked", TX_READY, 0);
    @(negedge CLK);
    chk("contention_rd_first", {CSN, WEN, OEN}, 3'b010);
    rc = cyc;
    RXRDY = 1'b0;
    send(8'h7E, a3);
    chk("contention_tx_spacing", a3 - rc, 2 + GUARD);
    chk("ferr_cnt_contention", FERR_CNT, 1);
    FRAMING_ERR = 1'b0;

    // Back-pressure: no further reads while the holding register is full.
    wait_idle();
    RX_READY = 1'b0;
    DATA_OUT = 8'h01;
    rx_q.push_back(10'h001);
    RXRDY = 1'b1;
    wait_strobe(1'b0, "bp_first_read");
    @(posedge CLK);
    #1;
    DATA_OUT = 8'h02;
    n0 = rd_count;
    for (int i = 0; i < 15; i++) begin
      OVERFLOW = (i >= 2 && i < 5) || (i >= 8 && i < 10);
      @(posedge CLK);
      #1;
    end
    OVERFLOW = 1'b0;
    chk("bp_no_read", rd_count, n0);
    chk("bp_rx_held", {RX_VALID, RX_DATA}, 9'h101);
    chk("ovf_cnt", OVF_CNT, 2);
    rx_q.push_back(10'h002);
    RX_READY = 1'b1;
    wait_strobe(1'b0, "bp_release_read");
    RXRDY = 1'b0;
    wait_idle();
    chk("bp_drained", RX_VALID, 0);

    // Counter clear, then saturation of the framing counter.
    CNT_CLR = 1'b1;
    @(posedge CLK);
    #1;
    CNT_CLR = 1'b0;
    chk("cnt_clr", {PERR_CNT, FERR_CNT, OVF_CNT}, 0);
    for (int k = 0; k < 5; k++) begin
      recv(8'h40 + 8'(k), 1'b0, 1'b1, 1'b0);
      chk("ferr_sat", FERR_CNT, ferr_tbl[k]);
    end
    recv(8'h99, 1'b0, 1'b1, 1'b1);
    chk("clr_beats_inc", FERR_CNT, 0);
    FRAMING_ERR = 1'b0;

    // Reset in the middle of a write.
    wait_idle();
    TX_DATA = 8'hE7;
    wr_q.push_back(8'hE7);
    TX_VALID = 1'b1;
    wait_strobe(1'b1, "midwr_strobe");
    TX_VALID = 1'b0;
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    chk("midwr_strobes", {CSN, WEN, OEN}, 3'b111);
    chk("midwr_data_in", DATA_IN, 0);
    RESET = 1'b0;

    // Reset in the middle of a read: nothing captured or counted.
    wait_idle();
    DATA_OUT = 8'h77;
    PARITY_ERR = 1'b1;
    RXRDY = 1'b1;
    wait_strobe(1'b0, "midrd_strobe");
    RXRDY = 1'b0;
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    chk("midrd_strobes", {CSN, WEN, OEN}, 3'b111);
    chk("midrd_rx_valid", RX_VALID, 0);
    chk("midrd_perr_cnt", PERR_CNT, 0);
    RESET = 1'b0;
    PARITY_ERR = 1'b0;

    wait_idle();
    chk("wr_q_empty", wr_q.size(), 0);
    chk("rx_q_empty", rx_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
